// File: rtl/fpu_op_arbiter.sv
// fpu_op_arbiter: round-robin front end that shares one FPU datapath between
// NREQ requesters. A grant captures opcode and operands, the operation is held
// for LATENCY cycles, then the tagged result waits in DONE until accepted.
// Optional build macro FPU_OP_ARBITER_OPCNT_EN adds a 32-bit OP_COUNT output
// counting result hand-offs.
// Arithmetic truncates (round toward zero); zero exponent is treated as zero
// and NaN/Inf operands are passed through unchanged (A checked first).
module fpu_op_arbiter #(
   parameter int NREQ    = 4,
   parameter int NX      = 8,
   parameter int NM      = 23,
   parameter int LATENCY = 2,
   localparam int N      = NX + NM + 1,
   localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NREQ-1:0]   REQ_VALID,
   output logic [NREQ-1:0]   REQ_READY,
   input  logic [2*NREQ-1:0] REQ_OP,
   input  logic [N*NREQ-1:0] REQ_A,
   input  logic [N*NREQ-1:0] REQ_B,
   output logic              RES_VALID,
   input  logic              RES_READY,
   output logic [IW-1:0]     RES_ID,
   output logic [N-1:0]      RES_DATA,
   output logic              BUSY
`ifdef FPU_OP_ARBITER_OPCNT_EN
   ,output logic [31:0]      OP_COUNT
`endif
);

   localparam int EMAX = (1 << NX) - 1;
   localparam int BIAS = (1 << (NX - 1)) - 1;
   localparam int AW   = NM + 5;      // carry | hidden | fraction | 3 guard bits
   localparam int QW   = 2 * NM + 3;  // dividend width for the quotient
   localparam logic [N-1:0] QNAN = {1'b0, {NX{1'b1}}, 1'b1, {(NM-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [1:0]    op;
      logic [N-1:0]  a;
      logic [N-1:0]  b;
   } op_req_t;

   function automatic logic is_spec(input logic [N-1:0] x);
      return x[N-2:NM] == {NX{1'b1}};
   endfunction

   function automatic logic is_zero(input logic [N-1:0] x);
      return x[N-2:NM] == {NX{1'b0}};
   endfunction

   // Saturates to signed Inf on overflow and flushes to signed zero on underflow.
   function automatic logic [N-1:0] fp_pack(input logic s, input int e, input logic [NM-1:0] f);
      if (e >= EMAX) return {s, {NX{1'b1}}, {NM{1'b0}}};
      if (e <= 0)    return {s, {(N-1){1'b0}}};
      return {s, NX'(e), f};
   endfunction

   function automatic logic [N-1:0] fp_add(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0]  x, y;
      logic [AW-1:0] mx, my, mr;
      int            d, p, e;
      if (is_spec(a)) return a;
      if (is_spec(b)) return b;
      if (is_zero(b)) return a;
      if (is_zero(a)) return b;
      // x carries the larger magnitude so the subtraction never borrows out
      if (a[N-2:0] >= b[N-2:0]) begin x = a; y = b; end
      else                      begin x = b; y = a; end
      mx = {2'b01, x[NM-1:0], 3'b000};
      my = {2'b01, y[NM-1:0], 3'b000};
      d  = int'(x[N-2:NM]) - int'(y[N-2:NM]);
      my = (d >= AW) ? '0 : (my >> d);
      mr = (x[N-1] == y[N-1]) ? (mx + my) : (mx - my);
      if (mr == '0) return '0;
      p = 0;
      for (int i = 0; i < AW; i++) if (mr[i]) p = i;
      e  = int'(x[N-2:NM]) + p - (NM + 3);
      mr = (p > NM + 3) ? (mr >> 1) : (mr << (NM + 3 - p));
      return fp_pack(x[N-1], e, mr[NM+2:3]);
   endfunction

   function automatic logic [N-1:0] fp_mul(input logic [N-1:0] a, input logic [N-1:0] b);
      logic              s;
      logic [2*NM+1:0]   pr;
      int                e;
      s = a[N-1] ^ b[N-1];
      if (is_spec(a)) return a;
      if (is_spec(b)) return b;
      if (is_zero(a) || is_zero(b)) return {s, {(N-1){1'b0}}};
      pr = (2*NM+2)'({1'b1, a[NM-1:0]}) * (2*NM+2)'({1'b1, b[NM-1:0]});
      e  = int'(a[N-2:NM]) + int'(b[N-2:NM]) - BIAS;
      if (pr[2*NM+1]) return fp_pack(s, e + 1, pr[2*NM:NM+1]);
      return fp_pack(s, e, pr[2*NM-1:NM]);
   endfunction

   function automatic logic [N-1:0] fp_div(input logic [N-1:0] a, input logic [N-1:0] b);
      logic          s;
      logic [QW-1:0] q;
      int            e;
      s = a[N-1] ^ b[N-1];
      if (is_spec(a)) return a;
      if (is_spec(b)) return b;
      if (is_zero(b)) return is_zero(a) ? QNAN : {s, {NX{1'b1}}, {NM{1'b0}}};
      if (is_zero(a)) return {s, {(N-1){1'b0}}};
      q = {1'b1, a[NM-1:0], {(NM+2){1'b0}}} / QW'({1'b1, b[NM-1:0]});
      e = int'(a[N-2:NM]) - int'(b[N-2:NM]) + BIAS;
      if (q[NM+2]) return fp_pack(s, e, q[NM+1:2]);
      return fp_pack(s, e - 1, q[NM:1]);
   endfunction

   state_t          state, state_nxt;
   logic [IW-1:0]   last, gnt_idx, scan_idx;
   logic            gnt_any;
   logic [NREQ-1:0] gnt_vec;
   logic [3:0]      cnt;
   op_req_t         cur, sel;
   logic [N-1:0]    fpu_res;

   // Round-robin search: first valid requester after the last one granted.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      scan_idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         scan_idx = IW'((int'(last) + k) % NREQ);
         if (REQ_VALID[scan_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = scan_idx;
         end
      end
   end

   // One-hot grant vector and the operand mux for the winning requester.
   always_comb begin
      gnt_vec = '0;
      sel     = '0;
      sel.id  = gnt_idx;
      for (int i = 0; i < NREQ; i++) begin
         gnt_vec[i] = gnt_any && (gnt_idx == IW'(i));
         if (gnt_idx == IW'(i)) begin
            sel.op = REQ_OP[2*i +: 2];
            sel.a  = REQ_A[N*i +: N];
            sel.b  = REQ_B[N*i +: N];
         end
      end
   end

   // FPU function selected by the captured opcode.
   always_comb begin
      fpu_res = '0;
      case (cur.op)
         2'd0: fpu_res = fp_add(cur.a, cur.b);
         2'd1: fpu_res = fp_add(cur.a, {~cur.b[N-1], cur.b[N-2:0]});
         2'd2: fpu_res = fp_mul(cur.a, cur.b);
         default: fpu_res = fp_div(cur.a, cur.b);
      endcase
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: grant -> EXEC for LATENCY cycles -> DONE until accepted.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt_any)       state_nxt = EXEC;
         EXEC:    if (cnt == 4'd0)   state_nxt = DONE;
         DONE:    if (RES_READY)     state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state; grants are only offered in IDLE.
   always_comb begin
      REQ_READY = (state == IDLE) ? gnt_vec : '0;
      RES_VALID = (state == DONE);
      BUSY      = (state != IDLE);
   end

   // Operand capture, latency countdown and result register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         last     <= IW'(NREQ - 1);
         cnt      <= '0;
         cur      <= '0;
         RES_DATA <= '0;
         RES_ID   <= '0;
      end else begin
         case (state)
            IDLE: if (gnt_any) begin
               cur  <= sel;
               last <= gnt_idx;
               cnt  <= 4'(LATENCY - 1);
            end
            EXEC: if (cnt == 4'd0) begin
               RES_DATA <= fpu_res;
               RES_ID   <= cur.id;
            end else begin
               cnt <= cnt - 4'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef FPU_OP_ARBITER_OPCNT_EN
   // Counts accepted results; wraps naturally at 2^32.
   always_ff @(posedge CLK) begin
      if (RST)                             OP_COUNT <= '0;
      else if (state == DONE && RES_READY) OP_COUNT <= OP_COUNT + 32'd1;
   end
`else
   // No hand-off counter in this build.
`endif

endmodule
